tmds_channel_decoder: RTL and testbench
=======================================

TMDS_CHANNEL_DECODER -- requirements
Module: tmds_channel_decoder

Interface
REQ-001 SHALL have parameter CTRL_RUN, default 16: consecutive control tokens that prove word alignment.
REQ-002 SHALL have parameter SEARCH_TIMEOUT, default 2048: cycles without a qualifying control run before a slip (SEARCH) or lock loss (LOCKED).
REQ-003 SHALL have parameter SLIP_WAIT, default 8: cycles ignored after each bitslip pulse.
REQ-004 SHALL have port clk_i  input  1  pixel clock; the only clock.
REQ-005 SHALL have port rst_n_i  input  1  synchronous, active-low reset.
REQ-006 SHALL have port tmds_word_i  input  10  raw deserialized word; bit 0 is the first bit on the wire.
REQ-007 SHALL have port bitslip_o  output  1  one-cycle pulse that requests a 1-bit deserializer shift.
REQ-008 SHALL have port aligned_o  output  1  high while in LOCKED.
REQ-009 SHALL have port data_o  output  8  decoded pixel byte.
REQ-010 SHALL have port ctrl_o  output  2  decoded control bits {C1,C0}.
REQ-011 SHALL have port de_o  output  1  high when the word is a data word and aligned.

Function
REQ-012 SHALL recognise control tokens 0x354->00, 0x0AB->01, 0x154->10, 0x2AB->11; every other word SHALL be a data word.
REQ-013 SHALL decode data words as d = q[9] ? ~q[7:0] : q[7:0]; out[0] = d[0]; out[i] = q[8] ? d[i]^d[i-1] : ~(d[i]^d[i-1]), for i = 1..7.
REQ-014 SHALL register data_o, ctrl_o and de_o with exactly one cycle of latency from tmds_word_i.
REQ-015 SHALL update ctrl_o on control tokens and hold it on data words.
REQ-016 SHALL update data_o on data words and hold it on control tokens.
REQ-017 SHALL force de_o=0 and ctrl_o=0 whenever aligned_o=0 (the same cycle, i.e. after the one-cycle pipeline).
REQ-018 SHALL implement states SEARCH, SLIP_WAIT and LOCKED, with reset state SEARCH.
REQ-019 SHALL keep a run counter that increments on each control token and clears on any data word.
REQ-020 SHALL keep a timeout counter that increments every cycle in SEARCH and LOCKED.
REQ-021 SEARCH: when the run counter reaches CTRL_RUN, the block SHALL enter LOCKED and raise aligned_o on the next cycle.
REQ-022 SEARCH: if the timeout counter reaches SEARCH_TIMEOUT-1 first, the block SHALL pulse bitslip_o for one cycle and enter SLIP_WAIT.
REQ-023 SEARCH: if the run target and the timeout occur in the same cycle, the run target SHALL win.
REQ-024 SLIP_WAIT: the block SHALL count SLIP_WAIT cycles, then return to SEARCH with both counters cleared, and SHALL not count run tokens during the wait.
REQ-025 LOCKED: reaching CTRL_RUN consecutive control tokens SHALL clear the timeout counter; the run counter saturates at CTRL_RUN.
REQ-026 LOCKED: a timeout reaching SEARCH_TIMEOUT-1 SHALL drop to SEARCH, lower aligned_o, clear both counters, and SHALL NOT pulse bitslip_o.
REQ-027 Counter widths SHALL be $clog2 of their limit plus 1, with no wrap-around.

Reset
REQ-028 While rst_n_i=0 at a clock edge, the block SHALL set state=SEARCH and clear all counters.
REQ-029 While rst_n_i=0, outputs SHALL be bitslip_o=0, aligned_o=0, data_o=0, ctrl_o=0, de_o=0.
REQ-030 Reset asserted mid-SLIP_WAIT or mid-LOCKED SHALL abort immediately, with no pending bitslip pulse.

Configuration
REQ-031 When TMDS_DEC_SLIP_CNT_EN is defined, the block SHALL add port slip_cnt_o (output, 16 bits) that counts bitslip pulses, saturates at 0xFFFF, is cleared by reset, and holds its value across lock and unlock.
REQ-032 When TMDS_DEC_SLIP_CNT_EN is undefined, the port and counter SHALL be absent and the remaining behaviour SHALL be identical.

Verification
REQ-033 Reset, then 16 consecutive 0x354 words -> aligned_o=1 one cycle after the 16th word accepted; ctrl_o=00, de_o=0.
REQ-034 Locked; drive 0x354, 0x0AB, 0x154, 0x2AB, then data word 0x100 -> ctrl_o=00/01/10/11 in turn, then de_o=1 with data_o=0x00, each one cycle after its input.
REQ-035 Reset; hold tmds_word_i=0x1AA (rotated token) -> bitslip_o pulses at cycle 2047, then every 2048+8 cycles; aligned_o stays 0; slip_cnt_o counts pulses (macro defined).
REQ-036 Locked; then 2048 data words with no control run -> aligned_o falls, de_o=0, no bitslip pulse.
REQ-037 Locked; then a 15-token run, then one data word, repeated -> lock lost after 2048 cycles, because a 15-token run never qualifies.
REQ-038 Assert rst_n_i for 1 cycle during SLIP_WAIT -> all outputs 0 next cycle; SEARCH restarts with a full 2048-cycle timeout.

Source files
------------

// File: rtl/tmds_channel_decoder.sv
// tmds_channel_decoder
// Decodes one TMDS channel: the four control tokens and 8b/10b-style data words.
// It also searches for 10-bit word alignment. While unaligned it requests a
// 1-bit deserializer shift (bitslip_o) whenever no run of CTRL_RUN consecutive
// control tokens appears within SEARCH_TIMEOUT cycles.
// Optional build macro: TMDS_DEC_SLIP_CNT_EN adds slip_cnt_o, a saturating count
// of bitslip pulses issued since reset.
module tmds_channel_decoder #(
   parameter int unsigned CTRL_RUN       = 16,
   parameter int unsigned SEARCH_TIMEOUT = 2048,
   parameter int unsigned SLIP_WAIT      = 8
) (
   input  logic        clk_i,
   input  logic        rst_n_i,
   input  logic [9:0]  tmds_word_i,
   output logic        bitslip_o,
   output logic        aligned_o,
   output logic [7:0]  data_o,
   output logic [1:0]  ctrl_o,
   output logic        de_o
`ifdef TMDS_DEC_SLIP_CNT_EN
   ,
   output logic [15:0] slip_cnt_o
`endif
);

   localparam int unsigned RUN_W  = $clog2(CTRL_RUN) + 1;
   localparam int unsigned TO_W   = $clog2(SEARCH_TIMEOUT) + 1;
   localparam int unsigned WAIT_W = $clog2(SLIP_WAIT) + 1;

   localparam logic [RUN_W-1:0]  RUN_TARGET = RUN_W'(CTRL_RUN);
   localparam logic [TO_W-1:0]   TO_LAST    = TO_W'(SEARCH_TIMEOUT - 1);
   localparam logic [WAIT_W-1:0] WAIT_LAST  = WAIT_W'(SLIP_WAIT - 1);

   localparam logic [9:0] TOK_C00 = 10'h354;
   localparam logic [9:0] TOK_C01 = 10'h0AB;
   localparam logic [9:0] TOK_C10 = 10'h154;
   localparam logic [9:0] TOK_C11 = 10'h2AB;

   typedef enum logic [1:0] {
      ST_SEARCH    = 2'd0,
      ST_SLIP_WAIT = 2'd1,
      ST_LOCKED    = 2'd2
   } state_t;

   state_t              state;
   logic [RUN_W-1:0]    run_cnt;
   logic [TO_W-1:0]     to_cnt;
   logic [WAIT_W-1:0]   wait_cnt;

   logic                is_ctrl_c;
   logic [1:0]          ctrl_bits_c;
   logic [7:0]          d_c;
   logic [7:0]          dec_c;
   logic [RUN_W-1:0]    run_next_c;
   logic                run_hit_c;
   logic                to_hit_c;
   logic                slip_fire_c;
   logic                aligned_next_c;

   // Classify the incoming word as one of the four control tokens or as data.
   always_comb begin
      is_ctrl_c   = 1'b1;
      ctrl_bits_c = 2'b00;
      case (tmds_word_i)
         TOK_C00: ctrl_bits_c = 2'b00;
         TOK_C01: ctrl_bits_c = 2'b01;
         TOK_C10: ctrl_bits_c = 2'b10;
         TOK_C11: ctrl_bits_c = 2'b11;
         default: is_ctrl_c   = 1'b0;
      endcase
   end

   // Undo the optional inversion, then the XOR/XNOR transition chain.
   always_comb begin
      d_c      = tmds_word_i[9] ? ~tmds_word_i[7:0] : tmds_word_i[7:0];
      dec_c    = '0;
      dec_c[0] = d_c[0];
      for (int i = 1; i < 8; i++) begin
         dec_c[i] = tmds_word_i[8] ? (d_c[i] ^ d_c[i-1]) : ~(d_c[i] ^ d_c[i-1]);
      end
   end

   // Run/timeout qualification and the alignment the FSM will hold after this edge.
   always_comb begin
      run_next_c = '0;
      if (is_ctrl_c) begin
         run_next_c = (run_cnt == RUN_TARGET) ? run_cnt : run_cnt + RUN_W'(1);
      end
      run_hit_c      = (run_next_c == RUN_TARGET);
      to_hit_c       = (to_cnt == TO_LAST);
      slip_fire_c    = (state == ST_SEARCH) && !run_hit_c && to_hit_c;
      aligned_next_c = ((state == ST_SEARCH) && run_hit_c) ||
                       ((state == ST_LOCKED) && (run_hit_c || !to_hit_c));
   end

   // Alignment FSM with its counters, bitslip pulse and aligned flag.
   always_ff @(posedge clk_i) begin
      if (!rst_n_i) begin
         state     <= ST_SEARCH;
         run_cnt   <= '0;
         to_cnt    <= '0;
         wait_cnt  <= '0;
         bitslip_o <= 1'b0;
         aligned_o <= 1'b0;
      end else begin
         bitslip_o <= 1'b0;
         case (state)
            ST_SEARCH: begin
               if (run_hit_c) begin
                  // A qualifying run beats a simultaneous timeout.
                  state     <= ST_LOCKED;
                  aligned_o <= 1'b1;
                  run_cnt   <= run_next_c;
                  to_cnt    <= '0;
               end else if (to_hit_c) begin
                  state     <= ST_SLIP_WAIT;
                  bitslip_o <= 1'b1;
                  run_cnt   <= '0;
                  to_cnt    <= '0;
                  wait_cnt  <= '0;
               end else begin
                  run_cnt   <= run_next_c;
                  to_cnt    <= to_cnt + TO_W'(1);
               end
            end
            ST_SLIP_WAIT: begin
               // Deserializer output is unsettled here; tokens are not counted.
               run_cnt <= '0;
               to_cnt  <= '0;
               if (wait_cnt == WAIT_LAST) begin
                  state    <= ST_SEARCH;
                  wait_cnt <= '0;
               end else begin
                  wait_cnt <= wait_cnt + WAIT_W'(1);
               end
            end
            ST_LOCKED: begin
               if (run_hit_c) begin
                  run_cnt <= run_next_c;
                  to_cnt  <= '0;
               end else if (to_hit_c) begin
                  // Lock lost: search again at the current slip position.
                  state     <= ST_SEARCH;
                  aligned_o <= 1'b0;
                  run_cnt   <= '0;
                  to_cnt    <= '0;
               end else begin
                  run_cnt <= run_next_c;
                  to_cnt  <= to_cnt + TO_W'(1);
               end
            end
            default: begin
               state     <= ST_SEARCH;
               aligned_o <= 1'b0;
               run_cnt   <= '0;
               to_cnt    <= '0;
               wait_cnt  <= '0;
            end
         endcase
      end
   end

   // One-cycle decode pipeline; ctrl_o and de_o are qualified by next-cycle alignment.
   always_ff @(posedge clk_i) begin
      if (!rst_n_i) begin
         data_o <= '0;
         ctrl_o <= '0;
         de_o   <= 1'b0;
      end else begin
         if (!is_ctrl_c) begin
            data_o <= dec_c;
         end
         if (!aligned_next_c) begin
            ctrl_o <= '0;
         end else if (is_ctrl_c) begin
            ctrl_o <= ctrl_bits_c;
         end
         de_o <= aligned_next_c && !is_ctrl_c;
      end
   end

`ifdef TMDS_DEC_SLIP_CNT_EN
   // Saturating count of bitslip requests; survives lock and unlock.
   always_ff @(posedge clk_i) begin
      if (!rst_n_i) begin
         slip_cnt_o <= '0;
      end else if (slip_fire_c && (slip_cnt_o != 16'hFFFF)) begin
         slip_cnt_o <= slip_cnt_o + 16'd1;
      end
   end
`endif

endmodule

// File: tb/tb_tmds_channel_decoder.sv
// Self-checking bench for tmds_channel_decoder (optionally with TMDS_DEC_SLIP_CNT_EN).
module tb_tmds_channel_decoder;

   localparam int CTRL_RUN       = 16;
   localparam int SEARCH_TIMEOUT = 2048;
   localparam int SLIP_WAIT      = 8;
   localparam int SLIP_PERIOD    = SEARCH_TIMEOUT + SLIP_WAIT;

   logic        clk_i;
   logic        rst_n_i;
   logic [9:0]  tmds_word_i;
   logic        bitslip_o;
   logic        aligned_o;
   logic [7:0]  data_o;
   logic [1:0]  ctrl_o;
   logic        de_o;
`ifdef TMDS_DEC_SLIP_CNT_EN
   logic [15:0] slip_cnt_o;
`endif

   int n_cmp  = 0;
   int n_fail = 0;

   logic [9:0] toks [4] = '{10'h354, 10'h0AB, 10'h154, 10'h2AB};

   // Behavioural model state
   bit         m_locked;
   int         m_run;
   int         m_age;
   int         m_wait;
   bit         m_slip;
   logic [7:0] m_data;
   logic [1:0] m_ctrl;
   bit         m_de;
   int         m_slips;

   tmds_channel_decoder #(
      .CTRL_RUN      (CTRL_RUN),
      .SEARCH_TIMEOUT(SEARCH_TIMEOUT),
      .SLIP_WAIT     (SLIP_WAIT)
   ) dut (
      .clk_i      (clk_i),
      .rst_n_i    (rst_n_i),
      .tmds_word_i(tmds_word_i),
      .bitslip_o  (bitslip_o),
      .aligned_o  (aligned_o),
      .data_o     (data_o),
      .ctrl_o     (ctrl_o),
      .de_o       (de_o)
`ifdef TMDS_DEC_SLIP_CNT_EN
      ,
      .slip_cnt_o (slip_cnt_o)
`endif
   );

   initial clk_i = 1'b0;
   always #5 clk_i = ~clk_i;

   function automatic int token_value(input logic [9:0] w);
      case (w)
         10'h354: return 0;
         10'h0AB: return 1;
         10'h154: return 2;
         10'h2AB: return 3;
         default: return -1;
      endcase
   endfunction

   function automatic logic [7:0] ref_decode(input logic [9:0] q);
      logic [7:0] d;
      logic [7:0] o;
      d    = q[9] ? (8'hFF - q[7:0]) : q[7:0];
      o    = '0;
      o[0] = d[0];
      for (int i = 1; i < 8; i++) o[i] = ((d[i] != d[i-1]) == q[8]);
      return o;
   endfunction

   // TMDS transmit-side transition encoding (DC balance choice is random here).
   function automatic logic [9:0] tmds_encode(input logic [7:0] b, input bit use_xnor, input bit invert);
      logic [7:0] qm;
      qm[0] = b[0];
      for (int i = 1; i < 8; i++) qm[i] = use_xnor ? ~(qm[i-1] ^ b[i]) : (qm[i-1] ^ b[i]);
      return {invert, ~use_xnor, invert ? ~qm : qm};
   endfunction

   task automatic model_reset();
      m_locked = 0; m_run = 0; m_age = 0; m_wait = 0; m_slip = 0;
      m_data = '0; m_ctrl = '0; m_de = 0; m_slips = 0;
   endtask

   task automatic model_step(input logic [9:0] w, input logic [7:0] b);
      int t;
      t      = token_value(w);
      m_slip = 0;
      if (m_wait > 0) begin
         m_wait--;
         m_run = 0;
         m_age = 0;
      end else begin
         m_run = (t >= 0) ? m_run + 1 : 0;
         if (m_run >= CTRL_RUN) begin
            m_locked = 1;
            m_age    = 0;
         end else if (m_age == SEARCH_TIMEOUT - 1) begin
            if (m_locked) m_locked = 0;
            else begin
               m_slip = 1;
               m_wait = SLIP_WAIT;
               if (m_slips < 65535) m_slips++;
            end
            m_run = 0;
            m_age = 0;
         end else begin
            m_age++;
         end
      end
      if (t < 0) m_data = b;
      if (!m_locked) m_ctrl = '0;
      else if (t >= 0) m_ctrl = 2'(t);
      m_de = m_locked && (t < 0);
   endtask

   task automatic step(input logic [9:0] w, input logic [7:0] b);
      tmds_word_i = w;
      @(posedge clk_i);
      #1;
      model_step(w, b);
   endtask

   task automatic step_raw(input logic [9:0] w);
      step(w, ref_decode(w));
   endtask

   task automatic step_byte(input logic [7:0] b);
      logic [9:0] w;
      do w = tmds_encode(b, 1'($urandom_range(0, 1)), 1'($urandom_range(0, 1)));
      while (token_value(w) >= 0);
      step(w, b);
   endtask

   task automatic do_reset();
      rst_n_i     = 1'b0;
      tmds_word_i = 10'($urandom_range(0, 1023));
      @(posedge clk_i);
      #1;
      model_reset();
      rst_n_i = 1'b1;
   endtask

   task automatic lock_up();
      for (int i = 0; i < CTRL_RUN; i++) step_raw(10'h354);
   endtask

   task automatic test_reset();
      rst_n_i     = 1'b0;
      tmds_word_i = 10'h354;
      repeat (2) @(posedge clk_i);
      #1;
      model_reset();
      n_cmp++; if (bitslip_o !== 1'b0) begin n_fail++; $display("FAIL reset_bitslip: got %b expected 0", bitslip_o); end
      n_cmp++; if (aligned_o !== 1'b0) begin n_fail++; $display("FAIL reset_aligned: got %b expected 0", aligned_o); end
      n_cmp++; if (data_o !== 8'h00) begin n_fail++; $display("FAIL reset_data: got %h expected 00", data_o); end
      n_cmp++; if (ctrl_o !== 2'b00) begin n_fail++; $display("FAIL reset_ctrl: got %b expected 00", ctrl_o); end
      n_cmp++; if (de_o !== 1'b0) begin n_fail++; $display("FAIL reset_de: got %b expected 0", de_o); end
`ifdef TMDS_DEC_SLIP_CNT_EN
      n_cmp++; if (slip_cnt_o !== 16'd0) begin n_fail++; $display("FAIL reset_slip_cnt: got %0d expected 0", slip_cnt_o); end
`endif
      rst_n_i = 1'b1;
   endtask

   task automatic test_lock();
      do_reset();
      for (int i = 1; i <= CTRL_RUN; i++) begin
         step_raw(10'h354);
         n_cmp++;
         if (aligned_o !== (i == CTRL_RUN)) begin
            n_fail++; $display("FAIL lock_aligned token %0d: got %b expected %b", i, aligned_o, (i == CTRL_RUN));
         end
      end
      n_cmp++; if (ctrl_o !== 2'b00) begin n_fail++; $display("FAIL lock_ctrl: got %b expected 00", ctrl_o); end
      n_cmp++; if (de_o !== 1'b0) begin n_fail++; $display("FAIL lock_de: got %b expected 0", de_o); end
      n_cmp++; if (bitslip_o !== 1'b0) begin n_fail++; $display("FAIL lock_bitslip: got %b expected 0", bitslip_o); end
   endtask

   task automatic test_tokens();
      do_reset();
      lock_up();
      for (int i = 0; i < 4; i++) begin
         step_raw(toks[i]);
         n_cmp++; if (ctrl_o !== 2'(i)) begin n_fail++; $display("FAIL tok_ctrl %0d: got %b expected %b", i, ctrl_o, 2'(i)); end
         n_cmp++; if (de_o !== 1'b0) begin n_fail++; $display("FAIL tok_de %0d: got %b expected 0", i, de_o); end
      end
      step(10'h136, 8'h5A);
      n_cmp++; if (data_o !== 8'h5A) begin n_fail++; $display("FAIL tok_data5a: got %h expected 5a", data_o); end
      n_cmp++; if (de_o !== 1'b1) begin n_fail++; $display("FAIL tok_de5a: got %b expected 1", de_o); end
      n_cmp++; if (ctrl_o !== 2'b11) begin n_fail++; $display("FAIL tok_ctrl_hold: got %b expected 11", ctrl_o); end
      step_raw(10'h154);
      n_cmp++; if (data_o !== 8'h5A) begin n_fail++; $display("FAIL tok_data_hold: got %h expected 5a", data_o); end
      n_cmp++; if (ctrl_o !== 2'b10) begin n_fail++; $display("FAIL tok_ctrl10: got %b expected 10", ctrl_o); end
      step_raw(10'h100);
      n_cmp++; if (data_o !== 8'h00) begin n_fail++; $display("FAIL tok_data100: got %h expected 00", data_o); end
      n_cmp++; if (de_o !== 1'b1) begin n_fail++; $display("FAIL tok_de100: got %b expected 1", de_o); end
      n_cmp++; if (aligned_o !== 1'b1) begin n_fail++; $display("FAIL tok_aligned: got %b expected 1", aligned_o); end
   endtask

   task automatic test_lock_loss();
      int slips;
      slips = 0;
      do_reset();
      lock_up();
      for (int k = 1; k <= SEARCH_TIMEOUT; k++) begin
         step_byte(8'($urandom_range(0, 255)));
         if (bitslip_o !== 1'b0) slips++;
         n_cmp++;
         if (aligned_o !== (k < SEARCH_TIMEOUT) || de_o !== (k < SEARCH_TIMEOUT)) begin
            n_fail++; $display("FAIL loss_aligned_de word %0d: got %b/%b expected %b", k, aligned_o, de_o, (k < SEARCH_TIMEOUT));
         end
      end
      n_cmp++; if (slips != 0) begin n_fail++; $display("FAIL loss_bitslip: got %0d pulses expected 0", slips); end
   endtask

   task automatic test_short_runs();
      int lost_at;
      lost_at = -1;
      do_reset();
      lock_up();
      step_byte(8'($urandom_range(0, 255)));
      for (int k = 2; k <= SEARCH_TIMEOUT + 100 && lost_at < 0; k++) begin
         if (((k - 2) % 16) < 15) step_raw(toks[$urandom_range(0, 3)]);
         else step_byte(8'($urandom_range(0, 255)));
         if (aligned_o !== 1'b1) lost_at = k;
      end
      n_cmp++; if (lost_at != SEARCH_TIMEOUT) begin n_fail++; $display("FAIL short_runs_loss: got word %0d expected %0d", lost_at, SEARCH_TIMEOUT); end
   endtask

   task automatic test_slip();
      int pulses[$];
      int aligned_hi;
      aligned_hi = 0;
      do_reset();
      for (int s = 0; s < SEARCH_TIMEOUT + 2 * SLIP_PERIOD; s++) begin
         step_raw(10'h1AA);
         if (bitslip_o !== 1'b0) pulses.push_back(s);
         if (aligned_o !== 1'b0) aligned_hi++;
      end
      n_cmp++; if (pulses.size() != 3) begin n_fail++; $display("FAIL slip_pulses: got %0d expected 3", pulses.size()); end
      for (int i = 0; i < 3 && i < pulses.size(); i++) begin
         n_cmp++;
         if (pulses[i] != SEARCH_TIMEOUT - 1 + i * SLIP_PERIOD) begin
            n_fail++; $display("FAIL slip_cycle %0d: got %0d expected %0d", i, pulses[i], SEARCH_TIMEOUT - 1 + i * SLIP_PERIOD);
         end
      end
      n_cmp++; if (aligned_hi != 0) begin n_fail++; $display("FAIL slip_aligned: got %0d high cycles expected 0", aligned_hi); end
`ifdef TMDS_DEC_SLIP_CNT_EN
      n_cmp++; if (slip_cnt_o !== 16'd3) begin n_fail++; $display("FAIL slip_cnt: got %0d expected 3", slip_cnt_o); end
`endif
   endtask

   task automatic test_reset_in_wait();
      int first;
      first = -1;
      do_reset();
      for (int s = 0; s < SEARCH_TIMEOUT; s++) step_raw(10'h1AA);
      n_cmp++; if (bitslip_o !== 1'b1) begin n_fail++; $display("FAIL wait_pre_pulse: got %b expected 1", bitslip_o); end
      repeat (3) step_raw(10'h1AA);
      rst_n_i = 1'b0;
      @(posedge clk_i);
      #1;
      model_reset();
      n_cmp++; if (bitslip_o !== 1'b0) begin n_fail++; $display("FAIL wait_rst_bitslip: got %b expected 0", bitslip_o); end
      n_cmp++; if (aligned_o !== 1'b0) begin n_fail++; $display("FAIL wait_rst_aligned: got %b expected 0", aligned_o); end
      n_cmp++; if (data_o !== 8'h00) begin n_fail++; $display("FAIL wait_rst_data: got %h expected 00", data_o); end
      n_cmp++; if (ctrl_o !== 2'b00) begin n_fail++; $display("FAIL wait_rst_ctrl: got %b expected 00", ctrl_o); end
      n_cmp++; if (de_o !== 1'b0) begin n_fail++; $display("FAIL wait_rst_de: got %b expected 0", de_o); end
      rst_n_i = 1'b1;
      for (int s = 0; s < SEARCH_TIMEOUT + 16 && first < 0; s++) begin
         step_raw(10'h1AA);
         if (bitslip_o === 1'b1) first = s;
      end
      n_cmp++; if (first != SEARCH_TIMEOUT - 1) begin n_fail++; $display("FAIL wait_restart: got cycle %0d expected %0d", first, SEARCH_TIMEOUT - 1); end
`ifdef TMDS_DEC_SLIP_CNT_EN
      n_cmp++; if (slip_cnt_o !== 16'd1) begin n_fail++; $display("FAIL wait_slip_cnt: got %0d expected 1", slip_cnt_o); end
`endif
   endtask

   task automatic test_reset_mid_lock();
      do_reset();
      lock_up();
      step_byte(8'h3C);
      n_cmp++; if (de_o !== 1'b1 || data_o !== 8'h3C) begin n_fail++; $display("FAIL midlock_pre: got de %b data %h expected 1/3c", de_o, data_o); end
      rst_n_i = 1'b0;
      @(posedge clk_i);
      #1;
      model_reset();
      n_cmp++;
      if ({bitslip_o, aligned_o, data_o, ctrl_o, de_o} !== 13'd0) begin
         n_fail++; $display("FAIL midlock_rst: got bs %b al %b data %h ctrl %b de %b expected all 0", bitslip_o, aligned_o, data_o, ctrl_o, de_o);
      end
      rst_n_i = 1'b1;
   endtask

   task automatic test_random();
      int s;
      s = 0;
      do_reset();
      while (s < 12000) begin
         int kind;
         int len;
         kind = int'($urandom_range(0, 9));
         if (kind <= 3) len = int'($urandom_range(1, 20));
         else if (kind <= 8) len = int'($urandom_range(1, 40));
         else len = int'($urandom_range(2000, 2600));
         for (int j = 0; j < len; j++) begin
            if (kind <= 3) step_raw(toks[$urandom_range(0, 3)]);
            else if ($urandom_range(0, 1) == 1) step_byte(8'($urandom_range(0, 255)));
            else step_raw(10'($urandom_range(0, 1023)));
            n_cmp++; if (bitslip_o !== m_slip) begin n_fail++; $display("FAIL rand_bitslip @%0d: got %b expected %b", s, bitslip_o, m_slip); end
            n_cmp++; if (aligned_o !== m_locked) begin n_fail++; $display("FAIL rand_aligned @%0d: got %b expected %b", s, aligned_o, m_locked); end
            n_cmp++; if (de_o !== m_de) begin n_fail++; $display("FAIL rand_de @%0d: got %b expected %b", s, de_o, m_de); end
            n_cmp++; if (ctrl_o !== m_ctrl) begin n_fail++; $display("FAIL rand_ctrl @%0d: got %b expected %b", s, ctrl_o, m_ctrl); end
            n_cmp++; if (data_o !== m_data) begin n_fail++; $display("FAIL rand_data @%0d: got %h expected %h", s, data_o, m_data); end
`ifdef TMDS_DEC_SLIP_CNT_EN
            n_cmp++; if (slip_cnt_o !== 16'(m_slips)) begin n_fail++; $display("FAIL rand_slip_cnt @%0d: got %0d expected %0d", s, slip_cnt_o, m_slips); end
`endif
            s++;
         end
      end
   endtask

   initial begin
      rst_n_i     = 1'b0;
      tmds_word_i = '0;
      model_reset();
      test_reset();
      test_lock();
      test_tokens();
      test_lock_loss();
      test_short_runs();
      test_slip();
      test_reset_in_wait();
      test_reset_mid_lock();
      test_random();
      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
      $finish;
   end

endmodule
